// File: rtl/exp_uart_pkg.sv
// exp_uart_pkg: shared definitions for the expansion-port UART card.
// Holds the register map, STATUS/CTRL bit positions and the TX/RX FSM state
// encodings used by exp_uart.
package exp_uart_pkg;

    // Register index, taken from cpu_addr[2:0]
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_DIVL   = 3'd3;
    localparam logic [2:0] REG_DIVH   = 3'd4;

    // STATUS bit positions
    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_OVR      = 3;
    localparam int ST_FERR     = 4;

    // CTRL bit positions
    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/exp_uart_fifo.sv
// exp_uart_fifo: synchronous FIFO with simultaneous push/pop.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (flushes pointers)
//   push, din       - write request and data; ignored when full
//   pop             - read request; ignored when empty
//   dout            - head entry (valid when !empty)
//   full, empty     - occupancy flags
//   count           - number of stored entries
module exp_uart_fifo #(
    parameter int  DEPTH = 16,
    parameter int  W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage holds data only; no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/exp_uart.sv
// exp_uart: expansion-bus serial card (Z80 I/O responder) with an 8N1 UART,
// TX/RX FIFOs and a programmable 16x baud divisor.
// Ports:
//   clk, reset           - system clock, synchronous active-high reset
//   cpu_addr, cpu_dout   - expansion address bus and CPU write data
//   iorq, rd, wr, m1     - active-high Z80 bus strobes
//   cpu_din              - read data to CPU, 8'hFF when not selected
//   irq                  - level interrupt request (registered)
//   rxd / txd            - serial in (asynchronous) / serial out (idle high)
module exp_uart
    import exp_uart_pkg::*;
#(
    parameter logic [7:0]  BASE       = 8'hF8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        iorq,
    input  logic        rd,
    input  logic        wr,
    input  logic        m1,
    output logic [7:0]  cpu_din,
    output logic        irq,
    input  logic        rxd,
    output logic        txd
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode and once-per-cycle strobe edges
    logic       sel, rd_sel, wr_sel, rd_edge, wr_edge;
    logic       rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
    logic [2:0] idx;

    // Registers
    logic [1:0]  ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic        div_wr, tick;
    logic        ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;

    // FIFOs
    logic          tx_push, tx_pop, tx_fifo_empty, tx_full;
    logic          rx_push, rx_pop, rx_fifo_empty, rx_full;
    logic [7:0]    tx_dout, rx_dout;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_empty, rx_avail;

    // TX path
    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [3:0] tx_tck_q, tx_tck_d;
    logic       txd_q, txd_d;

    // RX path
    logic       rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic       rx_fall, rx_ferr_set;
    rx_state_e  rx_state_q, rx_state_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [3:0] rx_tck_q, rx_tck_d;

    // Interrupt-acknowledge cycles (m1 high) never select the card.
    assign sel     = iorq & ~m1 & (cpu_addr[15:8] == BASE) & (cpu_addr[7:3] == 5'd0);
    assign idx     = cpu_addr[2:0];
    assign rd_sel  = sel & rd;
    assign wr_sel  = sel & wr;
    assign rd_edge = rd_sel & ~rd_prev_q;
    assign wr_edge = wr_sel & ~wr_prev_q;

    assign tx_empty = (tx_count == '0);
    assign rx_avail = (rx_count != '0);
    assign tx_push  = wr_edge & (idx == REG_DATA);
    assign rx_pop   = rd_edge & (idx == REG_DATA) & ~rx_fifo_empty;
    assign tick     = (cnt_q == 16'd0);

    assign irq = irq_q;
    assign txd = txd_q;

    exp_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .din   (cpu_dout),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_fifo_empty),
        .count (tx_count)
    );

    exp_uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .din   (rx_shift_q),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_fifo_empty),
        .count (rx_count)
    );

    // Read mux: combinational from registered state. An empty DATA read gives 0.
    always_comb begin
        cpu_din = 8'hFF;
        if (rd_sel) begin
            case (idx)
                REG_DATA: cpu_din = rx_fifo_empty ? 8'h00 : rx_dout;
                REG_STATUS: begin
                    cpu_din              = 8'h00;
                    cpu_din[ST_RX_AVAIL] = rx_avail;
                    cpu_din[ST_TX_FULL]  = tx_full;
                    cpu_din[ST_TX_EMPTY] = tx_empty;
                    cpu_din[ST_OVR]      = ovr_q;
                    cpu_din[ST_FERR]     = ferr_q;
                end
                REG_CTRL: cpu_din = {6'b0, ctrl_q};
                REG_DIVL: cpu_din = div_q[7:0];
                REG_DIVH: cpu_din = div_q[15:8];
                default:  cpu_din = 8'hFF;
            endcase
        end
    end

    // Register writes, sticky error flags, baud counter and irq
    always_comb begin
        rd_prev_d = rd_sel;
        wr_prev_d = wr_sel;
        ctrl_d    = ctrl_q;
        div_d     = div_q;
        div_wr    = 1'b0;
        ovr_d     = ovr_q;
        ferr_d    = ferr_q;
        if (wr_edge) begin
            case (idx)
                REG_CTRL: ctrl_d = cpu_dout[1:0];
                REG_DIVL: begin
                    div_d[7:0] = cpu_dout;
                    div_wr     = 1'b1;
                end
                REG_DIVH: begin
                    div_d[15:8] = cpu_dout;
                    div_wr      = 1'b1;
                end
                default: ;
            endcase
        end
        // Clear-on-read first so an error landing on the same clk is kept.
        if (rd_edge && idx == REG_STATUS) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (rx_push && rx_full) ovr_d = 1'b1;
        if (rx_ferr_set) ferr_d = 1'b1;

        if (div_wr)    cnt_d = div_d;
        else if (tick) cnt_d = div_q;
        else           cnt_d = cnt_q - 16'd1;

        irq_d = (ctrl_q[CTRL_RX_IE] & rx_avail) |
                (ctrl_q[CTRL_TX_IE] & tx_empty & (tx_state_q == TX_IDLE));
    end

    // TX FSM: every state advances on ticks only; 16 ticks per bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_tck_d   = tx_tck_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        if (tick) begin
            case (tx_state_q)
                TX_IDLE: begin
                    txd_d = 1'b1;
                    if (!tx_fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_dout;
                        tx_tck_d   = 4'd0;
                        txd_d      = 1'b0;
                        tx_state_d = TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tck_q == 4'd15) begin
                        tx_tck_d   = 4'd0;
                        tx_bit_d   = 3'd0;
                        txd_d      = tx_shift_q[0];
                        tx_state_d = TX_DATA;
                    end else begin
                        tx_tck_d = tx_tck_q + 4'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_tck_q == 4'd15) begin
                        tx_tck_d = 4'd0;
                        if (tx_bit_q == 3'd7) begin
                            txd_d      = 1'b1;
                            tx_state_d = TX_STOP;
                        end else begin
                            tx_bit_d   = tx_bit_q + 3'd1;
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                            txd_d      = tx_shift_q[1];
                        end
                    end else begin
                        tx_tck_d = tx_tck_q + 4'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_tck_q == 4'd15) begin
                        tx_tck_d = 4'd0;
                        // Chain straight into the next start bit when more data waits.
                        if (!tx_fifo_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_dout;
                            txd_d      = 1'b0;
                            tx_state_d = TX_START;
                        end else begin
                            txd_d      = 1'b1;
                            tx_state_d = TX_IDLE;
                        end
                    end else begin
                        tx_tck_d = tx_tck_q + 4'd1;
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end
    end

    // RX FSM: start bit re-checked at tick 8, later samples every 16 ticks (mid-bit).
    assign rx_fall = rx_prev_q & ~rx_s2_q;

    always_comb begin
        rx_s1_d     = rxd;
        rx_s2_d     = rx_s1_q;
        rx_prev_d   = rx_s2_q;
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_bit_d    = rx_bit_q;
        rx_tck_d    = rx_tck_q;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_tck_d   = 4'd0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_tck_q == 4'd7) begin
                        rx_tck_d = 4'd0;
                        rx_bit_d = 3'd0;
                        // Line high again at mid start bit: treat as a glitch.
                        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tck_d = rx_tck_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_tck_q == 4'd15) begin
                        rx_tck_d   = 4'd0;
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                        else                  rx_bit_d   = rx_bit_q + 3'd1;
                    end else begin
                        rx_tck_d = rx_tck_q + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_tck_q == 4'd15) begin
                        rx_tck_d    = 4'd0;
                        rx_push     = rx_s2_q;
                        rx_ferr_set = ~rx_s2_q;
                        rx_state_d  = RX_IDLE;
                    end else begin
                        rx_tck_d = rx_tck_q + 4'd1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_prev_q  <= 1'b0;
            wr_prev_q  <= 1'b0;
            ctrl_q     <= 2'b00;
            div_q      <= DIV_RESET;
            cnt_q      <= DIV_RESET;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_bit_q   <= 3'd0;
            tx_tck_q   <= 4'd0;
            txd_q      <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_bit_q   <= 3'd0;
            rx_tck_q   <= 4'd0;
        end else begin
            rd_prev_q  <= rd_prev_d;
            wr_prev_q  <= wr_prev_d;
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            irq_q      <= irq_d;
            tx_state_q <= tx_state_d;
            tx_bit_q   <= tx_bit_d;
            tx_tck_q   <= tx_tck_d;
            txd_q      <= txd_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_bit_q   <= rx_bit_d;
            rx_tck_q   <= rx_tck_d;
        end
    end

    // Shift registers carry data only.
    always_ff @(posedge clk) begin
        tx_shift_q <= tx_shift_d;
        rx_shift_q <= rx_shift_d;
    end

endmodule

// File: tb/tb_exp_uart.sv
`timescale 1ns/1ps
module tb_exp_uart;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        iorq, rd, wr, m1;
    logic [7:0]  cpu_din;
    logic        irq;
    logic        rxd;
    logic        txd;

    always #5 clk = ~clk;

    exp_uart dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .iorq     (iorq),
        .rd       (rd),
        .wr       (wr),
        .m1       (m1),
        .cpu_din  (cpu_din),
        .irq      (irq),
        .rxd      (rxd),
        .txd      (txd)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: RX FIFO contents and sticky flags.
    byte unsigned rxq[$];
    bit           ovr_m;
    bit           ferr_m;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    // STATUS as seen while the transmitter is idle with nothing queued.
    function automatic logic [7:0] status_m();
        return {3'b000, ferr_m, ovr_m, 1'b1, 1'b0, (rxq.size() != 0)};
    endfunction

    task automatic io_wr(input logic [15:0] a, input logic [7:0] d, input int hold);
        @(negedge clk);
        cpu_addr = a; cpu_dout = d; iorq = 1'b1; wr = 1'b1; m1 = 1'b0;
        repeat (hold) @(negedge clk);
        iorq = 1'b0; wr = 1'b0;
    endtask

    task automatic io_rd(input logic [15:0] a, input int hold, input logic m1v,
                         output logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; iorq = 1'b1; rd = 1'b1; m1 = m1v;
        #1 d = cpu_din;
        repeat (hold) @(negedge clk);
        iorq = 1'b0; rd = 1'b0; m1 = 1'b0;
    endtask

    task automatic status_check(input string tag);
        logic [7:0] d;
        io_rd(16'hF801, 1, 1'b0, d);
        check(tag, d, status_m());
        ovr_m  = 1'b0;
        ferr_m = 1'b0;
    endtask

    task automatic data_check(input string tag, input int hold);
        logic [7:0] d;
        logic [7:0] e;
        io_rd(16'hF800, hold, 1'b0, d);
        e = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
        check(tag, d, e);
    endtask

    // One 16-clk/bit serial frame on rxd, then the model takes its result.
    task automatic rx_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clk);
        end
        rxd = stop;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        if (!stop)                 ferr_m = 1'b1;
        else if (rxq.size() < 16)  rxq.push_back(b);
        else                       ovr_m = 1'b1;
    endtask

    // Transmit a byte with D=0 and check every bit boundary of the frame.
    task automatic tx_check(input logic [7:0] b);
        logic [9:0] frame;
        int k;
        frame = {1'b1, b, 1'b0};
        io_wr(16'hF800, b, 1);
        k = 0;
        while (txd !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("tx_start_seen", {7'b0, (k < 50)}, 8'h01);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d_first", i), {7'b0, txd}, {7'b0, frame[i]});
            repeat (15) @(negedge clk);
            check($sformatf("tx_bit%0d_last", i), {7'b0, txd}, {7'b0, frame[i]});
            @(negedge clk);
        end
        status_check("tx_done_status");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] b;

        reset = 1'b1; cpu_addr = 16'h0000; cpu_dout = 8'h00;
        iorq = 1'b0; rd = 1'b0; wr = 1'b0; m1 = 1'b0; rxd = 1'b1;
        rxq.delete(); ovr_m = 1'b0; ferr_m = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and decode
        check("reset_txd", {7'b0, txd}, 8'h01);
        check("reset_irq", {7'b0, irq}, 8'h00);
        check("idle_din", cpu_din, 8'hFF);
        status_check("reset_status");
        io_rd(16'hF701, 1, 1'b0, d); check("wrong_page", d, 8'hFF);
        io_rd(16'hF809, 1, 1'b0, d); check("addr_hi_bits", d, 8'hFF);
        io_rd(16'hF805, 1, 1'b0, d); check("reg5_read", d, 8'hFF);
        io_rd(16'hF803, 1, 1'b0, d); check("divl_reset", d, 8'h0F);
        io_rd(16'hF804, 1, 1'b0, d); check("divh_reset", d, 8'h00);

        // Divisor 0: one tick per clk, 16 clks per bit
        io_wr(16'hF803, 8'h00, 2);
        io_wr(16'hF804, 8'h00, 1);
        io_rd(16'hF803, 1, 1'b0, d); check("divl_readback", d, 8'h00);
        tx_check(8'hA5);
        tx_check(8'($urandom));

        // Receive two bytes; a held DATA read pops exactly once
        rx_frame(8'h3C, 1'b1);
        status_check("rx_one_status");
        rx_frame(8'($urandom), 1'b1);
        data_check("rx_held_read", 4);
        data_check("rx_second_read", 1);
        status_check("rx_drained_status");
        data_check("rx_empty_read", 1);

        // Short low pulse must be rejected
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        status_check("glitch_status");

        // Framing error: flag set, no data, cleared by reading STATUS
        rx_frame(8'($urandom), 1'b0);
        status_check("ferr_status");
        status_check("ferr_cleared");

        // Overrun: one byte more than the FIFO holds
        for (int i = 0; i < 17; i++) rx_frame(8'($urandom), 1'b1);
        status_check("ovr_status");
        status_check("ovr_cleared");
        for (int i = 0; i < 16; i++) data_check($sformatf("ovr_read%0d", i), 1);
        status_check("ovr_drained");

        // RX interrupt, ack cycle ignored, read clears the condition
        io_wr(16'hF802, 8'h01, 1);
        repeat (2) @(negedge clk);
        check("irq_idle", {7'b0, irq}, 8'h00);
        io_rd(16'hF802, 1, 1'b0, d); check("ctrl_read", d, 8'h01);
        b = 8'($urandom);
        rx_frame(b, 1'b1);
        check("irq_rx", {7'b0, irq}, 8'h01);
        io_rd(16'hF800, 1, 1'b1, d); check("ack_cycle", d, 8'hFF);
        status_check("ack_no_pop");
        data_check("irq_data_read", 1);
        repeat (2) @(negedge clk);
        check("irq_cleared", {7'b0, irq}, 8'h00);

        // TX-empty interrupt
        io_wr(16'hF802, 8'h02, 1);
        repeat (2) @(negedge clk);
        check("irq_tx_empty", {7'b0, irq}, 8'h01);

        // Reset in the middle of a transmitted frame
        io_wr(16'hF800, 8'($urandom), 1);
        io_wr(16'hF800, 8'($urandom), 1);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rxq.delete(); ovr_m = 1'b0; ferr_m = 1'b0;
        check("midframe_txd", {7'b0, txd}, 8'h01);
        check("midframe_irq", {7'b0, irq}, 8'h00);
        repeat (40) @(negedge clk);
        check("flushed_txd", {7'b0, txd}, 8'h01);
        status_check("flushed_status");
        io_rd(16'hF803, 1, 1'b0, d); check("divl_after_reset", d, 8'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
